// File: rtl/xor_chk_pkg.sv
// Shared types and helpers for the XOR datapath checker.
package xor_chk_pkg;

    typedef enum logic [1:0] {IDLE, WARMUP, CHECK, HALT} chk_state_e;

    localparam int MAX_LATENCY = 8;
    localparam int WARM_W      = $clog2(MAX_LATENCY + 1);

    // Saturating increment; callers pass the all-ones value of their counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/xor_chk_delay.sv
// {valid, data} shift pipeline of depth DEPTH; wires straight through when DEPTH is 0.
module xor_chk_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        assign out_vld  = in_vld;
        assign out_data = in_data;

        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, clr};
    end else begin : g_pipe
        logic [DEPTH-1:0]            vld_pipe;
        logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

        always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= in_vld;
                for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
        end

        // Payload only matters when its valid bit is set, so it is never cleared.
        always_ff @(posedge clk) begin
            dat_pipe[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) dat_pipe[i] <= dat_pipe[i-1];
        end

        assign out_vld  = vld_pipe[DEPTH-1];
        assign out_data = dat_pipe[DEPTH-1];
    end

endmodule

// File: rtl/xor_bind_checker.sv
// Observe-only checker for an instance computing c = a ^ b after LATENCY cycles;
// intended to be attached with a bind statement so the checked instance stays untouched.
module xor_bind_checker
    import xor_chk_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int LATENCY      = 0,
    parameter int CNT_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             active,
    output logic             mismatch,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs
);

    localparam int          WARM_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF >> (32 - CNT_W);

    chk_state_e        state, state_nxt;
    logic [WARM_W-1:0] warm_cnt, warm_nxt;

    logic              sync_clr;
    logic              tail_vld;
    logic [WIDTH-1:0]  tail_exp;
    logic              cmp_fail;

    assign sync_clr = !rst_n || clr;

    xor_chk_delay #(
        .WIDTH (WIDTH),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_vld   (en),
        .in_data  (a ^ b),
        .out_vld  (tail_vld),
        .out_data (tail_exp)
    );

    // Case inequality so X/Z on c is reported rather than silently passing.
    assign cmp_fail = tail_vld && (state == CHECK) && (tail_exp !== c);

    always_comb begin
        state_nxt = state;
        warm_nxt  = warm_cnt;
        unique case (state)
            IDLE: begin
                warm_nxt = '0;
                if (en) state_nxt = (LATENCY == 0) ? CHECK : WARMUP;
            end
            WARMUP: begin
                // Wait until the pipeline tail holds only entries pushed since en rose.
                if (!en) begin
                    state_nxt = IDLE;
                    warm_nxt  = '0;
                end else if (warm_cnt == WARM_W'(WARM_LAST)) begin
                    state_nxt = CHECK;
                    warm_nxt  = '0;
                end else begin
                    warm_nxt  = warm_cnt + 1'b1;
                end
            end
            CHECK: begin
                if (STOP_ON_FAIL != 0 && cmp_fail) state_nxt = HALT;
                else if (!en)                      state_nxt = IDLE;
            end
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            state    <= IDLE;
            warm_cnt <= '0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_nxt;
            active   <= (state_nxt == CHECK);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            mismatch     <= 1'b0;
            fail_sticky  <= 1'b0;
            mismatch_cnt <= '0;
            first_exp    <= '0;
            first_obs    <= '0;
        end else begin
            mismatch <= cmp_fail;
            if (cmp_fail) begin
                mismatch_cnt <= CNT_W'(sat_inc(32'(mismatch_cnt), CNT_MAX));
                // Only the first failure is kept for debug.
                if (!fail_sticky) begin
                    fail_sticky <= 1'b1;
                    first_exp   <= tail_exp;
                    first_obs   <= c;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_bind_checker.sv
// Scoreboard bench: three checker configurations driven by an ideal XOR source with injected faults.
module tb_xor_bind_checker;

    typedef struct {
        int         due;
        int         inst;
        string      tag;
        logic       act;
        logic       mm;
        logic       stk;
        logic [7:0] cnt;
        logic [3:0] fe;
        logic [3:0] fo;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [3];
    logic       clr   [3];
    logic       en    [3];
    logic [3:0] a     [3];
    logic [3:0] b     [3];
    logic [3:0] c     [3];
    logic [3:0] hist  [3][8];

    logic       act0, mm0, stk0, fe0, fo0;
    logic [7:0] cnt0;
    logic       act1, mm1, stk1;
    logic [2:0] cnt1;
    logic [3:0] fe1, fo1;
    logic       act2, mm2, stk2;
    logic [7:0] cnt2;
    logic [3:0] fe2, fo2;

    exp_t       sb[$];
    int         cyc   = 0;
    int         n_chk = 0;
    int         n_err = 0;
    string      cur_tag = "init";

    logic       e_act, e_mm, e_stk;
    logic [7:0] e_cnt;
    logic [3:0] e_fe, e_fo;

    xor_bind_checker #(.WIDTH(1), .LATENCY(0), .CNT_W(8), .STOP_ON_FAIL(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .clr(clr[0]),
        .a(a[0][0]), .b(b[0][0]), .c(c[0][0]),
        .active(act0), .mismatch(mm0), .fail_sticky(stk0), .mismatch_cnt(cnt0),
        .first_exp(fe0), .first_obs(fo0)
    );

    xor_bind_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(3), .STOP_ON_FAIL(0)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .clr(clr[1]),
        .a(a[1]), .b(b[1]), .c(c[1]),
        .active(act1), .mismatch(mm1), .fail_sticky(stk1), .mismatch_cnt(cnt1),
        .first_exp(fe1), .first_obs(fo1)
    );

    xor_bind_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(8), .STOP_ON_FAIL(1)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .clr(clr[2]),
        .a(a[2]), .b(b[2]), .c(c[2]),
        .active(act2), .mismatch(mm2), .fail_sticky(stk2), .mismatch_cnt(cnt2),
        .first_exp(fe2), .first_obs(fo2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    // Output of a correct DUT with the instance's latency.
    function automatic logic [3:0] good_c(input int i, input logic [3:0] av, input logic [3:0] bv);
        return (lat(i) == 0) ? (av ^ bv) : hist[i][lat(i)-1];
    endfunction

    task automatic step(input int i, input logic rn, input logic cl, input logic e,
                        input logic [3:0] av, input logic [3:0] bv,
                        input bit bad, input logic [3:0] cv);
        exp_t       x;
        logic [3:0] g;
        @(negedge clk);
        g        = good_c(i, av, bv);
        rst_n[i] = rn;
        clr[i]   = cl;
        en[i]    = e;
        a[i]     = av;
        b[i]     = bv;
        c[i]     = bad ? cv : g;
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = av ^ bv;
        x.due  = cyc + 1;
        x.inst = i;
        x.tag  = cur_tag;
        x.act  = e_act;
        x.mm   = e_mm;
        x.stk  = e_stk;
        x.cnt  = e_cnt;
        x.fe   = e_fe;
        x.fo   = e_fo;
        sb.push_back(x);
    endtask

    task automatic clear_exp();
        e_act = 1'b0; e_mm = 1'b0; e_stk = 1'b0;
        e_cnt = '0;   e_fe = '0;   e_fo  = '0;
    endtask

    always @(posedge clk) begin : mon
        exp_t       x;
        logic       o_act, o_mm, o_stk;
        logic [7:0] o_cnt;
        logic [3:0] o_fe, o_fo;
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            case (x.inst)
                0: begin o_act = act0; o_mm = mm0; o_stk = stk0; o_cnt = cnt0;
                         o_fe = {3'b0, fe0}; o_fo = {3'b0, fo0}; end
                1: begin o_act = act1; o_mm = mm1; o_stk = stk1; o_cnt = {5'b0, cnt1};
                         o_fe = fe1; o_fo = fo1; end
                default: begin o_act = act2; o_mm = mm2; o_stk = stk2; o_cnt = cnt2;
                         o_fe = fe2; o_fo = fo2; end
            endcase
            chk({x.tag, ".active"},    32'(o_act), 32'(x.act));
            chk({x.tag, ".mismatch"},  32'(o_mm),  32'(x.mm));
            chk({x.tag, ".sticky"},    32'(o_stk), 32'(x.stk));
            chk({x.tag, ".cnt"},       32'(o_cnt), 32'(x.cnt));
            chk({x.tag, ".first_exp"}, 32'(o_fe),  32'(x.fe));
            chk({x.tag, ".first_obs"}, 32'(o_fo),  32'(x.fo));
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] av, bv, g;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; clr[i] = 1'b0; en[i] = 1'b0;
            a[i] = '0; b[i] = '0; c[i] = '0;
            for (int k = 0; k < 8; k++) hist[i][k] = '0;
        end
        clear_exp();

        // Correct source, no latency: every a/b combination.
        cur_tag = "t1_reset";
        step(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);
        step(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);
        cur_tag = "t1_xor";
        e_act = 1'b1;
        for (int k = 0; k < 20; k++)
            step(0, 1'b1, 1'b0, 1'b1, 4'(k % 2), 4'((k / 2) % 2), 0, 4'h0);
        cur_tag = "t1_off";
        e_act = 1'b0;
        step(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);

        // Single forced fault with LATENCY=2.
        cur_tag = "t2_reset";
        clear_exp();
        step(1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);
        cur_tag = "t2_single";
        for (int k = 0; k < 17; k++) begin
            av = (k == 10) ? 4'h5 : 4'(k);
            bv = (k == 10) ? 4'h3 : 4'(3 * k);
            e_act = (k >= 2);
            if (k == 12) begin
                e_mm = 1'b1; e_cnt = 8'd1; e_stk = 1'b1; e_fe = 4'h6; e_fo = 4'h7;
            end else begin
                e_mm = 1'b0;
            end
            step(1, 1'b1, 1'b0, 1'b1, av, bv, k == 12, 4'h7);
        end

        // Ten consecutive faults against a 3-bit counter.
        cur_tag = "t3_clr";
        clear_exp();
        step(1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 0, 4'h0);
        cur_tag = "t3_sat";
        for (int k = 0; k < 14; k++) begin
            av = 4'(k + 1);
            bv = 4'(2 * k);
            g  = good_c(1, av, bv);
            e_act = (k >= 2);
            e_mm  = (k >= 4);
            if (k >= 4) begin
                e_stk = 1'b1;
                e_cnt = (k - 3 > 7) ? 8'd7 : 8'(k - 3);
            end
            if (k == 4) begin
                e_fe = g; e_fo = ~g;
            end
            step(1, 1'b1, 1'b0, 1'b1, av, bv, k >= 4, ~g);
        end

        // Reset right after a fault; nothing may move before the edge.
        cur_tag = "t4_reset";
        clear_exp();
        step(1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 0, 4'h0);
        #2;
        chk("t4_pre.mismatch", 32'(mm1),  32'd1);
        chk("t4_pre.cnt",      32'(cnt1), 32'd7);
        chk("t4_pre.sticky",   32'(stk1), 32'd1);
        chk("t4_pre.active",   32'(act1), 32'd1);
        cur_tag = "t4_after";
        step(1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);

        // Stop on first failure with LATENCY=3, then clear.
        cur_tag = "t5_reset";
        step(2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);
        cur_tag = "t5_halt";
        for (int k = 0; k < 12; k++) begin
            av = 4'(k);
            bv = 4'(k) ^ 4'h5;
            g  = good_c(2, av, bv);
            e_act = (k >= 3) && (k < 6);
            e_mm  = (k == 6);
            if (k == 6) begin
                e_cnt = 8'd1; e_stk = 1'b1; e_fe = g; e_fo = ~g;
            end
            step(2, 1'b1, 1'b0, 1'b1, av, bv, k >= 6, ~g);
        end
        cur_tag = "t5_clr";
        clear_exp();
        step(2, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 0, 4'h0);

        // Enable drop: corrupted c while draining and warming up must go unchecked.
        cur_tag = "t6_drop";
        for (int k = 0; k < 19; k++) begin
            av = 4'(k + 7);
            bv = 4'(5 * k);
            g  = good_c(2, av, bv);
            e_act = (k >= 3 && k <= 8) || (k >= 14);
            step(2, 1'b1, 1'b0, !(k == 9 || k == 10), av, bv, (k >= 10 && k <= 14), ~g);
        end
        cur_tag = "t6_off";
        e_act = 1'b0;
        step(2, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 0, 4'h0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
